ethernet_pt_nios2_cpu_debug_ocimem_ctrl: RTL and testbench
==========================================================

Name: ethernet_pt_nios2_cpu_debug_ocimem_ctrl

Overview:
This block is the on-chip debug memory controller that sits directly downstream of the debug-slave sysclk stage. It consumes `jdo` and the `ocimem` take-action strobes, and it produces `MonDReg`, `monitor_ready` and `monitor_error`, which feed back into the debug-slave TCK stage. It owns a single-port debug RAM of 2^ADDR_W x 32 bits. The CPU reaches this RAM through an Avalon-MM slave; JTAG reaches it through the strobes.

Parameters:
- ADDR_W, 8, word-address width of the debug RAM (depth 2^ADDR_W).
- INIT_FILE, "", optional RAM init file; an empty string means the RAM powers up with undefined contents.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- jdo  in  38  JTAG data from the sysclk stage
- take_action_ocimem_a  in  1  strobe: load address; read when jdo[34]=1
- take_action_ocimem_b  in  1  strobe: JTAG write of jdo[34:3]
- take_no_action_ocimem_a  in  1  strobe: post-increment address, then read
- address  in  ADDR_W  CPU word address
- read  in  1  CPU read request
- write  in  1  CPU write request
- writedata  in  32  CPU write data
- byteenable  in  4  CPU byte lanes
- debugaccess  in  1  CPU write permitted when high
- readdata  out  32  CPU read data
- waitrequest  out  1  Avalon stall
- MonDReg  out  32  JTAG read-data register
- MonAReg  out  ADDR_W  JTAG address register
- monitor_ready  out  1  JTAG read data valid
- monitor_error  out  1  sticky overrun flag

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-high, named `reset`.
- Reset values: `readdata`=0, `MonDReg`=0, `MonAReg`=0, `monitor_ready`=0, `monitor_error`=0, `waitrequest`=1, FSM=IDLE, pending flags=0. The RAM contents are not cleared.
- Strobe capture: the strobes are 1-cycle pulses and are registered into `jrd_pend` / `jwr_pend` on the strobe edge. The pending flags are cleared when the FSM leaves IDLE to service them.
- `take_action_ocimem_a`:
  - `MonAReg` <= jdo[ADDR_W+1:2].
  - If jdo[35]=1, `monitor_error` <= 0.
  - If jdo[34]=1, set `jrd_pend`.
  - `monitor_ready` <= 0.
- `take_no_action_ocimem_a`: `MonAReg` <= `MonAReg`+1 (mod 2^ADDR_W), set `jrd_pend`, `monitor_ready` <= 0.
- `take_action_ocimem_b`: latch jdo[34:3] into the write-data holding register and set `jwr_pend`.
- Overrun: a strobe that arrives while any pending flag is set, or while the FSM is in J_RD, J_CAP or J_WR, is dropped and sets `monitor_error` <= 1. Address and data registers are unchanged.
- Simultaneous strobes in one cycle: priority is ocimem_b, then ocimem_a, then no_action_a. The losing strobes count as overrun.
- FSM states: IDLE, J_RD, J_CAP, J_WR, C_RD, C_DONE.
  - IDLE, `jwr_pend`: go to J_WR.
  - IDLE, else `jrd_pend`: go to J_RD.
  - IDLE, else `read`: go to C_RD; RAM address is `address`.
  - IDLE, else `write`: RAM written the same cycle with `byteenable` masking, only if `debugaccess`=1; otherwise the write is dropped silently. `waitrequest`=0 this cycle; stay in IDLE.
  - J_RD: RAM read at `MonAReg`; go to J_CAP.
  - J_CAP: `MonDReg` <= RAM q, `monitor_ready` <= 1; go to IDLE.
  - J_WR: full-word write at `MonAReg`, then `MonAReg`++ (wraps 2^ADDR_W-1 to 0); go to IDLE.
  - C_RD: go to C_DONE.
  - C_DONE: `readdata` <= RAM q, `waitrequest`=0 for this cycle; go to IDLE.
- `waitrequest`: 1 in every state except the IDLE write-accept cycle and C_DONE. A CPU request seen in IDLE while a JTAG op is pending is stalled until the JTAG op completes.
- Latencies:
  - Uncontended JTAG read: `monitor_ready` rises 3 edges after the strobe edge.
  - Uncontended JTAG write: RAM updated 2 edges after the strobe edge.
  - CPU read: `waitrequest` low in the 3rd cycle of `read`.
  - CPU write: accepted in 1 cycle.
- Mid-operation interaction: a CPU op in progress (C_RD, C_DONE) always completes; a strobe arriving during it only pends.
- Reset mid-operation: the op is abandoned; a RAM write already clocked in that cycle persists.

Test Plan:
1. Reset, then preload `mem[5]`=0xDEADBEEF via a CPU write with `debugaccess`=1 and `byteenable`=0xF. Pulse `ocimem_a` with jdo[ADDR_W+1:2]=5 and jdo[34]=1 -> `MonAReg`=5; `monitor_ready`=1 exactly 3 edges later; `MonDReg`=0xDEADBEEF.
2. `ocimem_a` at addr 0xFF (jdo[34]=0), then `ocimem_b` with jdo[34:3]=0x12345678, then `ocimem_b` with 0x9ABCDEF0 -> `mem[0xFF]`=0x12345678, `mem[0x00]`=0x9ABCDEF0, `MonAReg`=0x01 (wrap).
3. With `mem[6]`=0x11, set `MonAReg`=5 and pulse `no_action_a` -> `MonAReg`=6, `MonDReg`=0x11, `monitor_ready` toggles 0 then 1.
4. CPU write to addr 3 with `byteenable`=0x2 and data 0xAABBCCDD over existing 0 -> `mem[3]`=0x0000CC00. Repeat with `debugaccess`=0 -> unchanged. CPU read addr 3 -> `waitrequest` is 1,1,0 and `readdata`=0x0000CC00.
5. Assert CPU `read` in the same cycle that `jrd_pend` is set -> the JTAG read is serviced first and `waitrequest` stays high until the JTAG op finishes. Both data values are correct.
6. Two `ocimem_b` pulses 1 cycle apart -> second dropped, `monitor_error`=1, only the first write lands. `ocimem_a` with jdo[35]=1 -> `monitor_error`=0. Assert `reset` during J_RD -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/ethernet_pt_nios2_cpu_debug_ocimem_ctrl.sv
// On-chip debug memory controller: arbitrates a single-port 32-bit debug RAM
// between the CPU Avalon-MM slave and JTAG monitor strobes from the sysclk stage.
module ethernet_pt_nios2_cpu_debug_ocimem_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter              INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    input  logic              debugaccess,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {
        IDLE,
        J_RD,
        J_CAP,
        J_WR,
        C_RD,
        C_DONE
    } state_t;

    state_t            state_q;
    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       ram_q;
    logic [31:0]       wdata_q;
    logic [31:0]       readdata_q;
    logic [31:0]       mon_d_q;
    logic [ADDR_W-1:0] mon_a_q;
    logic              jrd_pend_q;
    logic              jwr_pend_q;
    logic              ready_q;
    logic              error_q;

    logic              busy;
    logic              acc_a;
    logic              acc_b;
    logic              acc_n;
    logic              overrun;
    logic              cpu_wr_ok;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    // JTAG strobes are refused while another JTAG op is pending or in flight;
    // CPU ops in flight do not block them, the strobe simply waits as pending.
    always_comb begin
        busy    = jrd_pend_q | jwr_pend_q | (state_q == J_RD) |
                  (state_q == J_CAP) | (state_q == J_WR);
        acc_b   = take_action_ocimem_b & ~busy;
        acc_a   = take_action_ocimem_a & ~take_action_ocimem_b & ~busy;
        acc_n   = take_no_action_ocimem_a & ~take_action_ocimem_a &
                  ~take_action_ocimem_b & ~busy;
        if (busy) begin
            overrun = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        end else begin
            overrun = (take_action_ocimem_b & (take_action_ocimem_a | take_no_action_ocimem_a)) |
                      (take_action_ocimem_a & take_no_action_ocimem_a);
        end
        cpu_wr_ok = (state_q == IDLE) & ~jwr_pend_q & ~jrd_pend_q & ~read & write;
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = address;
        ram_wdata = writedata;
        case (state_q)
            IDLE: begin
                if (cpu_wr_ok && debugaccess) begin
                    ram_we = 1'b1;
                    ram_be = byteenable;
                end
            end
            J_RD: ram_addr = mon_a_q;
            J_WR: begin
                ram_we    = 1'b1;
                ram_be    = '1;
                ram_addr  = mon_a_q;
                ram_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wdata_q    <= '0;
            readdata_q <= '0;
            mon_d_q    <= '0;
            mon_a_q    <= '0;
            jrd_pend_q <= 1'b0;
            jwr_pend_q <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (acc_b) begin
                wdata_q    <= jdo[34:3];
                jwr_pend_q <= 1'b1;
            end
            if (acc_a) begin
                mon_a_q <= jdo[ADDR_W+1:2];
                ready_q <= 1'b0;
                if (jdo[34]) jrd_pend_q <= 1'b1;
                if (jdo[35]) error_q <= 1'b0;
            end
            if (acc_n) begin
                mon_a_q    <= mon_a_q + 1'b1;
                ready_q    <= 1'b0;
                jrd_pend_q <= 1'b1;
            end
            if (overrun) error_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (jwr_pend_q) begin
                        jwr_pend_q <= 1'b0;
                        state_q    <= J_WR;
                    end else if (jrd_pend_q) begin
                        jrd_pend_q <= 1'b0;
                        state_q    <= J_RD;
                    end else if (read) begin
                        state_q <= C_RD;
                    end
                end
                J_RD:  state_q <= J_CAP;
                J_CAP: begin
                    mon_d_q <= ram_q;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                J_WR: begin
                    mon_a_q <= mon_a_q + 1'b1;
                    state_q <= IDLE;
                end
                // Capture in C_RD so readdata is already valid while waitrequest is low.
                C_RD: begin
                    readdata_q <= ram_q;
                    state_q    <= C_DONE;
                end
                C_DONE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign waitrequest   = reset | ~(cpu_wr_ok | (state_q == C_DONE));
    assign readdata      = readdata_q;
    assign MonDReg       = mon_d_q;
    assign MonAReg       = mon_a_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_ethernet_pt_nios2_cpu_debug_ocimem_ctrl.sv
// Self-checking bench: directed scenarios plus randomized CPU/JTAG traffic
// checked against a transaction-level memory and monitor-register model.
module tb_ethernet_pt_nios2_cpu_debug_ocimem_ctrl;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [37:0]   jdo;
    logic          take_action_ocimem_a;
    logic          take_action_ocimem_b;
    logic          take_no_action_ocimem_a;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [3:0]    byteenable;
    logic          debugaccess;
    logic [31:0]   readdata;
    logic          waitrequest;
    logic [31:0]   MonDReg;
    logic [AW-1:0] MonAReg;
    logic          monitor_ready;
    logic          monitor_error;

    ethernet_pt_nios2_cpu_debug_ocimem_ctrl #(
        .ADDR_W    (AW),
        .INIT_FILE ("")
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .address                 (address),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .debugaccess             (debugaccess),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] mdl_mem [DEPTH];
    int unsigned mdl_addr = 0;
    bit          mdl_err  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int unsigned a, input logic [31:0] d,
                             input logic [3:0] be, input bit dbg);
        logic [31:0] mask;
        address     = AW'(a);
        writedata   = d;
        byteenable  = be;
        debugaccess = dbg;
        write       = 1'b1;
        #1;
        check_eq("cpu_wr_wait", {63'd0, waitrequest}, 64'd0);
        tick();
        write       = 1'b0;
        debugaccess = 1'b0;
        if (dbg) begin
            mask = 32'd0;
            for (int b = 0; b < 4; b++)
                if (be[b]) mask = mask | (32'hFF << (8 * b));
            mdl_mem[a] = (mdl_mem[a] & ~mask) | (d & mask);
        end
    endtask

    task automatic cpu_read(input int unsigned a, output logic [31:0] got);
        int  cyc;
        bit  done;
        address = AW'(a);
        read    = 1'b1;
        cyc     = 0;
        done    = 1'b0;
        got     = 32'hx;
        while (!done && cyc < 20) begin
            #1;
            cyc++;
            if (!waitrequest) begin
                done = 1'b1;
                got  = readdata;
            end
            @(posedge clk);
            #1;
        end
        read = 1'b0;
        check_eq("cpu_rd_done", {63'd0, done}, 64'd1);
        check_eq("cpu_rd_cycles", 64'(cyc), 64'd3);
        check_eq("cpu_rd_data", {32'd0, got}, {32'd0, mdl_mem[a]});
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!monitor_ready && n < 10) begin
            tick();
            n++;
        end
        check_eq("jtag_rd_latency", 64'(n), 64'd3);
        check_eq("jtag_rd_data", {32'd0, MonDReg}, {32'd0, mdl_mem[mdl_addr]});
    endtask

    task automatic jtag_addr(input int unsigned a, input bit rd, input bit clr);
        jdo              = '0;
        jdo[AW+1:2]      = AW'(a);
        jdo[34]          = rd;
        jdo[35]          = clr;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        mdl_addr = a % DEPTH;
        if (clr) mdl_err = 1'b0;
        check_eq("jtag_a_addr", 64'(MonAReg), 64'(mdl_addr));
        check_eq("jtag_a_ready_clr", {63'd0, monitor_ready}, 64'd0);
        check_eq("jtag_a_err", {63'd0, monitor_error}, {63'd0, mdl_err});
        if (rd) wait_ready();
        else tick();
    endtask

    task automatic jtag_next();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        mdl_addr = (mdl_addr + 1) % DEPTH;
        check_eq("jtag_n_addr", 64'(MonAReg), 64'(mdl_addr));
        check_eq("jtag_n_ready_clr", {63'd0, monitor_ready}, 64'd0);
        wait_ready();
    endtask

    task automatic jtag_write(input logic [31:0] d);
        jdo       = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        tick();
        tick();
        mdl_mem[mdl_addr] = d;
        mdl_addr = (mdl_addr + 1) % DEPTH;
        check_eq("jtag_wr_addr", 64'(MonAReg), 64'(mdl_addr));
    endtask

    initial begin
        logic [31:0] got;
        int          rdy_cyc;
        int          wr_cyc;
        int          cyc;

        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        address = '0;
        read = 1'b0;
        write = 1'b0;
        writedata = '0;
        byteenable = '0;
        debugaccess = 1'b0;
        tick();
        tick();
        check_eq("rst_readdata", {32'd0, readdata}, 64'd0);
        check_eq("rst_mondreg", {32'd0, MonDReg}, 64'd0);
        check_eq("rst_monareg", 64'(MonAReg), 64'd0);
        check_eq("rst_ready", {63'd0, monitor_ready}, 64'd0);
        check_eq("rst_error", {63'd0, monitor_error}, 64'd0);
        check_eq("rst_wait", {63'd0, waitrequest}, 64'd1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) cpu_write(i, $urandom, 4'hF, 1'b1);

        // 1: JTAG read of a CPU-written word
        cpu_write(5, 32'hDEADBEEF, 4'hF, 1'b1);
        jtag_addr(5, 1'b1, 1'b0);
        check_eq("t1_mondreg", {32'd0, MonDReg}, 64'hDEADBEEF);

        // 2: JTAG writes with address wrap
        jtag_addr(8'hFF, 1'b0, 1'b0);
        jtag_write(32'h12345678);
        jtag_write(32'h9ABCDEF0);
        check_eq("t2_wrap", 64'(MonAReg), 64'h01);
        cpu_read(8'hFF, got);
        check_eq("t2_mem_ff", {32'd0, got}, 64'h12345678);
        cpu_read(8'h00, got);
        check_eq("t2_mem_00", {32'd0, got}, 64'h9ABCDEF0);

        // 3: post-increment read
        cpu_write(6, 32'h11, 4'hF, 1'b1);
        jtag_addr(5, 1'b1, 1'b0);
        check_eq("t3_ready_before", {63'd0, monitor_ready}, 64'd1);
        jtag_next();
        check_eq("t3_addr", 64'(MonAReg), 64'd6);
        check_eq("t3_mondreg", {32'd0, MonDReg}, 64'h11);

        // 4: byte-enable and debugaccess gating
        cpu_write(3, 32'h0, 4'hF, 1'b1);
        cpu_write(3, 32'hAABBCCDD, 4'h2, 1'b1);
        cpu_read(3, got);
        check_eq("t4_merge", {32'd0, got}, 64'h0000CC00);
        cpu_write(3, 32'hFFFFFFFF, 4'hF, 1'b0);
        cpu_read(3, got);
        check_eq("t4_nodbg", {32'd0, got}, 64'h0000CC00);

        // 5: CPU read stalled behind a pending JTAG read
        jdo = '0;
        jdo[AW+1:2] = AW'(8'h20);
        jdo[34] = 1'b1;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        mdl_addr = 8'h20;
        address = AW'(8'h30);
        read = 1'b1;
        rdy_cyc = 0;
        wr_cyc = 0;
        cyc = 0;
        while (wr_cyc == 0 && cyc < 20) begin
            #1;
            cyc++;
            if (monitor_ready && rdy_cyc == 0) rdy_cyc = cyc;
            if (!waitrequest) begin
                wr_cyc = cyc;
                got = readdata;
            end
            tick();
        end
        read = 1'b0;
        check_eq("t5_ready_cycle", 64'(rdy_cyc), 64'd4);
        check_eq("t5_cpu_cycle", 64'(wr_cyc), 64'd6);
        check_eq("t5_jtag_data", {32'd0, MonDReg}, {32'd0, mdl_mem[8'h20]});
        check_eq("t5_cpu_data", {32'd0, got}, {32'd0, mdl_mem[8'h30]});

        // 6: back-to-back JTAG writes, second one dropped
        jtag_addr(8'h40, 1'b0, 1'b0);
        jdo = '0;
        jdo[34:3] = 32'hCAFE0001;
        take_action_ocimem_b = 1'b1;
        tick();
        jdo[34:3] = 32'hCAFE0002;
        tick();
        take_action_ocimem_b = 1'b0;
        tick();
        mdl_mem[8'h40] = 32'hCAFE0001;
        mdl_addr = 8'h41;
        mdl_err = 1'b1;
        check_eq("t6_error_set", {63'd0, monitor_error}, 64'd1);
        check_eq("t6_addr", 64'(MonAReg), 64'h41);
        cpu_read(8'h40, got);
        check_eq("t6_first_lands", {32'd0, got}, 64'hCAFE0001);
        cpu_read(8'h41, got);
        jtag_addr(8'h41, 1'b0, 1'b1);
        check_eq("t6_error_clr", {63'd0, monitor_error}, 64'd0);

        // Randomized traffic, one transaction at a time
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 4))
                0: cpu_write($urandom_range(0, DEPTH - 1), $urandom,
                             4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
                1: cpu_read($urandom_range(0, DEPTH - 1), got);
                2: jtag_addr($urandom_range(0, DEPTH - 1), 1'b1, $urandom_range(0, 1) == 1);
                3: jtag_write($urandom);
                default: jtag_next();
            endcase
            check_eq("rnd_error", {63'd0, monitor_error}, {63'd0, mdl_err});
        end

        // Reset while a JTAG read is in J_RD
        cpu_read(8'h40, got);
        jdo = '0;
        jdo[AW+1:2] = AW'(8'h10);
        jdo[34] = 1'b1;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        check_eq("rst_pre_error", {63'd0, monitor_error}, 64'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_readdata", {32'd0, readdata}, 64'd0);
        check_eq("mid_rst_mondreg", {32'd0, MonDReg}, 64'd0);
        check_eq("mid_rst_monareg", 64'(MonAReg), 64'd0);
        check_eq("mid_rst_ready", {63'd0, monitor_ready}, 64'd0);
        check_eq("mid_rst_error", {63'd0, monitor_error}, 64'd0);
        check_eq("mid_rst_wait", {63'd0, waitrequest}, 64'd1);
        tick();
        reset = 1'b0;
        mdl_addr = 0;
        mdl_err = 1'b0;
        tick();
        jtag_addr(8'h40, 1'b1, 1'b0);
        cpu_read(5, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
